// File: rtl/decoder_stream.sv
// decoder_stream
//   Registered code decoder with an input stability filter and a held output.
//   A code/mode pair has to be seen unchanged on STABLE_CYCLES consecutive
//   valid samples before it is decoded. The decoded word is then held until
//   downstream takes it. Saturating counters record accepted hits and errors.
//
//   Ports
//     clock      rising-edge clock
//     reset      synchronous, active-high
//     in_valid   in_code/in_mode are valid
//     in_ready   block is sampling (IDLE or FILTER), low during reset
//     in_code    CODE_W-bit code to decode
//     in_mode    00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved
//     out_valid  decoded result is held on out_data/out_err
//     out_ready  downstream accepts the held result
//     out_data   NUM_OUT-bit decoded word
//     out_err    code out of range or reserved mode; out_data is 0 then
//     hit_count  accepted results with out_err=0, saturating
//     err_count  accepted results with out_err=1, saturating
module decoder_stream #(
    parameter int CODE_W        = 3,
    parameter int NUM_OUT       = 7,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CODE_W-1:0]  in_code,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_data,
    output logic               out_err,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int SC_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    // A matching sample taken while the count equals this value completes the run.
    localparam logic [SC_W-1:0] STABLE_LAST = SC_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   cap_code_p0;
    logic [1:0]          cap_mode_p0;
    logic [SC_W-1:0]     stab_cnt;
    logic [NUM_OUT:0]    dec_in;
    logic [NUM_OUT:0]    dec_cap;

    // Returns {err, data}. The error case forces the data to zero.
    function automatic logic [NUM_OUT:0] decode(input logic [CODE_W-1:0] code,
                                                input logic [1:0]        mode);
        logic [NUM_OUT-1:0] d;
        logic               e;
        d = '0;
        e = (int'(code) >= NUM_OUT) || (mode == 2'b11);
        if (!e) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                case (mode)
                    2'b00:   d[i] = (i == int'(code));
                    2'b01:   d[i] = (i <= int'(code));
                    2'b10:   d[i] = (i != int'(code));
                    default: d[i] = 1'b0;
                endcase
            end
        end
        return {e, d};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign dec_in   = decode(in_code, in_mode);
    assign dec_cap  = decode(cap_code_p0, cap_mode_p0);
    assign in_ready = !reset && (state != HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cap_code_p0 <= '0;
            cap_mode_p0 <= '0;
            stab_cnt    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_err     <= 1'b0;
            hit_count   <= '0;
            err_count   <= '0;
        end else begin
            case (state)
                // ---- sampling: first valid sample starts a run
                IDLE: begin
                    if (in_valid) begin
                        cap_code_p0 <= in_code;
                        cap_mode_p0 <= in_mode;
                        stab_cnt    <= SC_W'(1);
                        if (STABLE_CYCLES == 1) begin
                            out_data  <= dec_in[NUM_OUT-1:0];
                            out_err   <= dec_in[NUM_OUT];
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= FILTER;
                        end
                    end
                end
                // ---- filtering: run continues only on identical valid samples
                FILTER: begin
                    if (!in_valid) begin
                        stab_cnt <= '0;
                        state    <= IDLE;
                    end else if (in_code != cap_code_p0 || in_mode != cap_mode_p0) begin
                        cap_code_p0 <= in_code;
                        cap_mode_p0 <= in_mode;
                        stab_cnt    <= SC_W'(1);
                    end else begin
                        stab_cnt <= stab_cnt + 1'b1;
                        if (stab_cnt == STABLE_LAST) begin
                            // Input equals capture here, so decoding the capture is exact.
                            out_data  <= dec_cap[NUM_OUT-1:0];
                            out_err   <= dec_cap[NUM_OUT];
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                // ---- holding: inputs ignored until downstream takes the result
                HOLD: begin
                    if (out_ready) begin
                        if (out_err) err_count <= sat_inc(err_count);
                        else         hit_count <= sat_inc(hit_count);
                        out_valid <= 1'b0;
                        stab_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    stab_cnt  <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
